// File: rtl/stereo_pixel_feeder.sv
// stereo_pixel_feeder: per-line right-pixel window presenting disparity candidates with each left pixel
module stereo_pixel_feeder #(
    parameter int                     PIXEL_WIDTH = 4,
    parameter int                     NUM_DISP    = 9,
    parameter int                     LINE_WIDTH  = 320,
    parameter logic [PIXEL_WIDTH-1:0] FILL_VALUE  = '1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [PIXEL_WIDTH-1:0]       left_in,
    input  logic [PIXEL_WIDTH-1:0]       right_in,
    input  logic                         valid_in,
    input  logic                         line_start_in,
    output logic [PIXEL_WIDTH-1:0]       left_pixel_out,
    output logic [PIXEL_WIDTH-1:0]       right_pixel_out [NUM_DISP-1:0],
    output logic                         valid_out,
    output logic [$clog2(LINE_WIDTH)-1:0] col_out,
    output logic                         line_done_out,
    output logic                         short_line_err_out
);
    localparam int CW = $clog2(LINE_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(LINE_WIDTH - 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_DISP - 1);

    typedef enum logic {FILL, STEADY} state_t;

    state_t                 state;
    logic [PIXEL_WIDTH-1:0] win    [NUM_DISP-1:0];
    logic [PIXEL_WIDTH-1:0] win_nx [NUM_DISP-1:0];
    logic [CW-1:0]          col_q;
    logic [CW-1:0]          x;
    logic                   restart;

    // column of the incoming pair and the window it produces; a restart flushes the old row
    always_comb begin
        restart   = line_start_in || col_q == '0;
        x         = restart ? '0 : col_q;
        win_nx[0] = right_in;
        for (int k = 1; k < NUM_DISP; k++)
            win_nx[k] = restart ? FILL_VALUE : win[k-1];
    end

    // accept every valid pair, register its candidates one cycle later and track row position
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < NUM_DISP; k++) begin
                win[k]             <= FILL_VALUE;
                right_pixel_out[k] <= '0;
            end
            left_pixel_out     <= '0;
            valid_out          <= 1'b0;
            col_out            <= '0;
            line_done_out      <= 1'b0;
            short_line_err_out <= 1'b0;
            col_q              <= '0;
            state              <= FILL;
        end else begin
            valid_out     <= valid_in;
            line_done_out <= valid_in && x == LAST;
            if (valid_in) begin
                win                <= win_nx;
                right_pixel_out    <= win_nx;
                left_pixel_out     <= left_in;
                col_out            <= x;
                col_q              <= x == LAST ? '0 : x + 1'b1;
                short_line_err_out <= short_line_err_out || (line_start_in && col_q != '0);
                state              <= restart ? FILL : (x == FULL ? STEADY : state);
            end
        end
    end
endmodule

// File: doc/stereo_pixel_feeder.md
Name: stereo_pixel_feeder

Overview:
- Producer side of the stereo matcher's pixel interface.
- Accepts one raster-ordered left/right pixel pair per valid cycle.
- Keeps a per-line shift window of the last NUM_DISP right pixels.
- Presents each left pixel together with its NUM_DISP right-image disparity candidates (right column x-d for d=0..NUM_DISP-1) plus valid. These outputs feed the matcher's left_pixel_in / right_pixel_in / valid_in directly.

Parameters:
- PIXEL_WIDTH, 4, bits per pixel.
- NUM_DISP, 9, number of disparity candidates (window depth).
- LINE_WIDTH, 320, pixels per image row.
- FILL_VALUE, all-ones (PIXEL_WIDTH bits), value substituted for candidates left of column 0.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- left_in  input  PIXEL_WIDTH  left-image pixel
- right_in  input  PIXEL_WIDTH  right-image pixel, same row/column as left_in
- valid_in  input  1  pixel pair present this cycle
- line_start_in  input  1  pixel pair is column 0 of a row; sampled only when valid_in=1
- left_pixel_out  output  PIXEL_WIDTH  registered left pixel
- right_pixel_out  output  PIXEL_WIDTH x NUM_DISP (unpacked [NUM_DISP-1:0])  candidate d = right pixel at column x-d
- valid_out  output  1  one-cycle strobe, outputs valid
- col_out  output  $clog2(LINE_WIDTH)  column x of the current output
- line_done_out  output  1  one-cycle strobe with the output for column LINE_WIDTH-1
- short_line_err_out  output  1  sticky error flag

Behaviour:
- One clock (clk_in). Reset is synchronous and active-high (rst_in); all state changes on the rising edge.
- Reset state:
  - left_pixel_out=0, all right_pixel_out=0, valid_out=0, col_out=0, line_done_out=0, short_line_err_out=0.
  - Internal window all FILL_VALUE; column counter col_q=0; FSM in FILL.
- Accept: a pixel pair is accepted on any cycle with valid_in=1. There is no backpressure; every valid pair is consumed.
- Latency: exactly 1 cycle. The output for an accepted pair appears the following cycle with valid_out=1.
- valid_out=0 on cycles after a non-valid input. Data outputs and col_out then hold their last values.
- Column assignment:
  - The accepted pair gets x=0 if line_start_in=1 or col_q=0; otherwise x=col_q.
  - After acceptance, col_q=x+1, wrapping to 0 when x=LINE_WIDTH-1.
- Window update on accept:
  - If x=0: win[0]=right_in and win[1..NUM_DISP-1]=FILL_VALUE. The previous row's contents must not leak.
  - Otherwise shift: win[0]=right_in, win[k]=old win[k-1].
- Output rules:
  - right_pixel_out[d] is the right pixel at column x-d when x>=d, else FILL_VALUE. left_pixel_out=left_in. col_out=x.
  - line_done_out=1 in the same cycle as the output for x=LINE_WIDTH-1; otherwise 0.
- FSM (tracks window fill):
  - FILL: x<NUM_DISP-1. Some candidates are FILL_VALUE.
  - STEADY: all candidates are real pixels.
  - FILL->STEADY on accepting x=NUM_DISP-1.
  - Any x=0 accept returns to FILL, including a wrap or a mid-line line_start_in.
- Simultaneous events:
  - line_start_in=1 with col_q!=0 (row shorter than LINE_WIDTH): restart at x=0 and set short_line_err_out=1, sticky until rst_in.
  - line_start_in=1 with col_q=0: normal, no error.
- line_start_in with valid_in=0 is ignored.
- Reset mid-line: the next accepted pair is x=0 regardless of line_start_in. An output already registered is discarded (valid_out=0 the cycle after reset).

Test Plan:
- Reset then 12 pairs with line_start on the first; left=5, right=column index mod 16.
  -> Each valid_out one cycle after input. For x=3: right_pixel_out = {0:3, 1:2, 2:1, 3:0, 4..8:F}. For x=10: right_pixel_out[d]=10-d.
- Gapped valid_in (1,0,0,1 pattern) over 4 pairs.
  -> valid_out mirrors input with 1-cycle delay; outputs and col_out hold during gaps; the window shifts only on accepts.
- Full row of LINE_WIDTH=320 pairs followed by the next row with line_start_in=0.
  -> line_done_out pulses exactly once with col_out=319. The next pair reports col_out=0 with candidates 1..8 = F.
- line_start_in asserted at col_q=100.
  -> The output shows col_out=0, candidates 1..8 = F, short_line_err_out=1 and stays 1 over later rows until rst_in.
- rst_in pulsed at col_q=50 while valid_in=1.
  -> valid_out=0 the next cycle and all outputs 0. The first post-reset pair gives col_out=0, right_pixel_out[1..8]=F, err=0.
- Row in STEADY then line_start_in with valid_in=0.
  -> Ignored; the next valid pair continues at x=col_q with no error.
